rv_fetch_ctrl: RTL and testbench

- Sequences the fetch PC register against a pipelined instruction-memory port with a valid/grant handshake.
- Drives the fetch stall input so the PC advances only when a request is granted.
- Tracks in-flight requests and buffers returned instructions with their PCs for decode.
- On a redirect from execute, discards stale responses so decode only sees the correct path.

---
 rtl/rv_fetch_pkg.sv | 16 +
 rtl/rv_fetch_queue.sv | 96 +++++++++
 rtl/rv_fetch_ctrl.sv | 99 +++++++++
 tb/tb_rv_fetch_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types for the fetch controller: FSM state and the fetch-buffer entry.
package rv_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } fetch_ctrl_state_t;

  typedef struct packed {
    logic [31:2] pc;
    logic [31:0] instr;
    logic        ready;
  } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_queue.sv
// In-order fetch buffer: alloc at tail, fill oldest pending, pop head, clear all.
// One-cycle write-to-visible; fullness is tracked by count, never by pointer compare.
module rv_fetch_queue
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_alloc,
  input  logic [31:2]      i_alloc_pc,
  input  logic             i_fill,
  input  logic [31:0]      i_fill_data,
  input  logic             i_pop,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_alloc_cnt,
  output logic [CNT_W-1:0] o_pend_cnt,
  output logic             o_head_ready,
  output logic [31:0]      o_head_instr,
  output logic [31:2]      o_head_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   DEPTH_P = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);

  fetch_entry_t     ent_q [DEPTH];
  fetch_entry_t     ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, fill_idx;
  logic [CNT_W-1:0] alloc_q, alloc_d, pend_q, pend_d;
  logic [PTR_W:0]   fill_sum;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready entries sit ahead of pending ones, so the oldest pending is head + ready count.
  always_comb begin
    fill_sum = {1'b0, head_q} + (PTR_W + 1)'(alloc_q - pend_q);
    fill_idx = (fill_sum >= DEPTH_P) ? PTR_W'(fill_sum - DEPTH_P) : PTR_W'(fill_sum);
  end

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    alloc_d = alloc_q;
    pend_d  = pend_q;
    if (i_clear) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].ready = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      alloc_d = '0;
      pend_d  = '0;
    end else begin
      if (i_alloc) begin
        ent_d[tail_q] = '{pc: i_alloc_pc, instr: '0, ready: 1'b0};
        tail_d        = ptr_inc(tail_q);
      end
      if (i_fill) begin
        ent_d[fill_idx].instr = i_fill_data;
        ent_d[fill_idx].ready = 1'b1;
      end
      if (i_pop) begin
        ent_d[head_q].ready = 1'b0;
        head_d              = ptr_inc(head_q);
      end
      alloc_d = alloc_q + CNT_W'(i_alloc) - CNT_W'(i_pop);
      pend_d  = pend_q + CNT_W'(i_alloc) - CNT_W'(i_fill);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      alloc_q <= '0;
      pend_q  <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      alloc_q <= alloc_d;
      pend_q  <= pend_d;
    end
  end

  assign o_alloc_cnt  = alloc_q;
  assign o_pend_cnt   = pend_q;
  assign o_head_ready = ent_q[head_q].ready;
  assign o_head_instr = ent_q[head_q].instr;
  assign o_head_pc    = ent_q[head_q].pc;

endmodule

// File: rtl/rv_fetch_ctrl.sv
// Fetch PC sequencer over a valid/grant imem port; grant N -> instr visible N+2.
// Requests stop when DEPTH entries are allocated; a redirect drops stale responses.
module rv_fetch_ctrl
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:2] i_pc,
  input  logic        i_redirect,
  output logic        o_fetch_stall,
  output logic        o_imem_req,
  output logic [31:2] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:2] o_instr_pc,
  input  logic        i_dec_ready
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_ctrl_state_t state_q, state_d;
  logic [CNT_W-1:0]  drop_q, drop_d, owed;
  logic [CNT_W-1:0]  alloc_cnt, pend_cnt;
  logic              clear, fill, alloc, pop;

  always_comb begin
    state_d       = state_q;
    drop_d        = drop_q;
    o_imem_req    = 1'b0;
    o_fetch_stall = 1'b1;
    clear         = 1'b0;
    // Responses still owed to the dead path, net of one returning this cycle.
    owed = drop_q + pend_cnt;
    if (i_imem_rvalid && owed != '0) owed = owed - CNT_W'(1);
    case (state_q)
      BOOT: begin
        o_fetch_stall = 1'b0;
        state_d       = RUN;
      end
      RUN: begin
        o_imem_req    = !i_redirect && (alloc_cnt < DEPTH_C);
        o_fetch_stall = !(o_imem_req && i_imem_gnt);
      end
      FLUSH: begin
        if (i_imem_rvalid && drop_q != '0) begin
          drop_d = drop_q - CNT_W'(1);
          if (drop_q == CNT_W'(1)) state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
    if (i_redirect && state_q != BOOT) begin
      clear   = 1'b1;
      drop_d  = owed;
      state_d = (owed == '0) ? RUN : FLUSH;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= BOOT;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  assign o_imem_addr = i_pc;
  assign alloc       = o_imem_req && i_imem_gnt;
  assign fill        = i_imem_rvalid && (state_q == RUN) && (pend_cnt != '0);
  assign pop         = o_instr_valid && i_dec_ready && !clear;

  rv_fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_queue (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_alloc      (alloc),
    .i_alloc_pc   (i_pc),
    .i_fill       (fill),
    .i_fill_data  (i_imem_rdata),
    .i_pop        (pop),
    .i_clear      (clear),
    .o_alloc_cnt  (alloc_cnt),
    .o_pend_cnt   (pend_cnt),
    .o_head_ready (o_instr_valid),
    .o_head_instr (o_instr),
    .o_head_pc    (o_instr_pc)
  );

  a_no_orphan_rvalid : assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (i_imem_rvalid && state_q != FLUSH) |-> (pend_cnt != '0));

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// Random-stimulus bench for rv_fetch_ctrl against an epoch-tagged transaction model.
module tb_rv_fetch_ctrl;

  localparam int          DEPTH      = 2;
  localparam logic [31:2] RESET_ADDR = '0;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [31:2] i_pc = '0;
  logic        i_redirect = 1'b0;
  logic        o_fetch_stall;
  logic        o_imem_req;
  logic [31:2] o_imem_addr;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:2] o_instr_pc;
  logic        i_dec_ready = 1'b0;

  rv_fetch_ctrl #(.DEPTH(DEPTH)) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_pc          (i_pc),
    .i_redirect    (i_redirect),
    .o_fetch_stall (o_fetch_stall),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_instr_valid (o_instr_valid),
    .o_instr       (o_instr),
    .o_instr_pc    (o_instr_pc),
    .i_dec_ready   (i_dec_ready)
  );

  always #5 i_clk = ~i_clk;

  // Memory transactions carry the redirect epoch they were issued in.
  typedef struct {
    logic [31:2] addr;
    int          epoch;
    int          gcyc;
  } mem_t;
  typedef struct {
    logic [31:2] pc;
    bit          done;
    logic [31:0] data;
  } live_t;

  mem_t        mq[$];
  live_t       lq[$];
  int          epoch = 0;
  int          cyc = 0;
  bit          boot = 1'b0;
  bit          force_redir = 1'b0;
  logic [31:2] pc;
  int          n_vec = 0;
  int          n_err = 0;
  int          p_gnt, p_rv, p_rdy, p_redir;

  function automatic logic [31:0] mem_data(input logic [31:2] a);
    return {a, 2'b11} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic apply_reset();
    i_reset_n     = 1'b0;
    i_imem_gnt    = 1'b0;
    i_imem_rvalid = 1'b0;
    i_redirect    = 1'b0;
    i_dec_ready   = 1'b0;
    i_imem_rdata  = '0;
    #1;
    check("rst_req",   {31'd0, o_imem_req},    32'd0);
    check("rst_stall", {31'd0, o_fetch_stall}, 32'd0);
    check("rst_valid", {31'd0, o_instr_valid}, 32'd0);
    check("rst_instr", o_instr,                32'd0);
    check("rst_ipc",   {2'b00, o_instr_pc},    32'd0);
    mq.delete();
    lq.delete();
    epoch++;
    boot = 1'b1;
    pc   = RESET_ADDR - 30'd1;
    repeat (2) @(posedge i_clk);
    #2 i_reset_n = 1'b1;
  endtask

  task automatic step();
    bit          gnt, rdy, redir, rv, flushing, exp_req, exp_stall, exp_valid;
    int          stale;
    logic [31:2] tgt;
    mem_t        m;
    @(negedge i_clk);
    gnt   = ($urandom_range(99) < p_gnt);
    rdy   = ($urandom_range(99) < p_rdy);
    redir = !boot && (force_redir || ($urandom_range(999) < p_redir));
    rv    = (mq.size() > 0) && (mq[0].gcyc < cyc) && ($urandom_range(99) < p_rv);
    tgt   = 30'($urandom);
    i_pc          = pc;
    i_imem_gnt    = gnt;
    i_dec_ready   = rdy;
    i_redirect    = redir;
    i_imem_rvalid = rv;
    i_imem_rdata  = rv ? mem_data(mq[0].addr) : $urandom;

    stale = 0;
    foreach (mq[i]) if (mq[i].epoch != epoch) stale++;
    flushing  = (stale > 0);
    exp_req   = !boot && !flushing && !redir && (lq.size() < DEPTH);
    exp_stall = boot ? 1'b0 : !(exp_req && gnt);
    exp_valid = (lq.size() > 0) && lq[0].done;

    #1;
    check("req",   {31'd0, o_imem_req},    {31'd0, exp_req});
    check("stall", {31'd0, o_fetch_stall}, {31'd0, exp_stall});
    check("valid", {31'd0, o_instr_valid}, {31'd0, exp_valid});
    if (exp_req) check("addr", {2'b00, o_imem_addr}, {2'b00, pc});
    if (exp_valid) begin
      check("instr_pc", {2'b00, o_instr_pc}, {2'b00, lq[0].pc});
      check("instr",    o_instr,             lq[0].data);
    end

    if (rv) begin
      m = mq.pop_front();
      if (m.epoch == epoch) begin
        for (int i = 0; i < lq.size(); i++) begin
          if (!lq[i].done) begin
            lq[i].done = 1'b1;
            lq[i].data = mem_data(m.addr);
            break;
          end
        end
      end
    end
    if (exp_valid && rdy && !redir) void'(lq.pop_front());
    if (exp_req && gnt) begin
      mq.push_back('{addr: pc, epoch: epoch, gcyc: cyc});
      lq.push_back('{pc: pc, done: 1'b0, data: '0});
    end
    if (redir) begin
      lq.delete();
      epoch++;
      pc = tgt;
    end else if (!exp_stall) begin
      pc = pc + 30'd1;
    end
    boot = 1'b0;
    @(posedge i_clk);
    cyc++;
  endtask

  task automatic phase(input int n, input int g, input int r, input int d, input int x);
    p_gnt   = g;
    p_rv    = r;
    p_rdy   = d;
    p_redir = x;
    repeat (n) step();
  endtask

  initial begin
    i_reset_n = 1'b1;
    #3;
    apply_reset();
    phase(20,   100, 100, 100, 0);
    phase(30,   100, 100, 0,   0);
    phase(20,   100, 100, 100, 0);
    phase(1500, 70,  60,  60,  40);
    phase(1500, 40,  30,  80,  80);

    // Fill both slots with pending requests, redirect into FLUSH, then reset mid-cycle.
    phase(10, 0,   100, 100, 0);
    phase(4,  100, 0,   0,   0);
    force_redir = 1'b1;
    step();
    force_redir = 1'b0;
    step();
    @(negedge i_clk);
    #2;
    apply_reset();

    phase(800, 80, 50, 50, 30);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
